// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART timing constants and arbiter state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int TICKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'b001,
      ARB_START = 3'b010,
      ARB_WAIT  = 3'b100
   } arb_state_e;

   // Ticks to hold off after a start pulse: start + data + stop bits, plus a guard.
   function automatic int wait_ticks(input int ticks_per_bit, input int nb_data,
                                     input int nb_stop, input int guard_ticks);
      return ticks_per_bit * (1 + nb_data + nb_stop) + guard_ticks;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_select.sv
// ============================================================================
// Module : rr_priority_select
// Brief  : Combinational round-robin pick of the first valid index after i_last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_select #(
   parameter int N_REQ = 4,
   parameter int NB_ID = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [NB_ID-1:0] i_last,
   output logic [N_REQ-1:0] o_grant_onehot,
   output logic [NB_ID-1:0] o_grant_idx,
   output logic             o_any
);

   always_comb begin
      o_grant_idx = '0;
      o_any       = 1'b0;
      // Scan farthest-first so the nearest valid index after i_last wins.
      for (int off = N_REQ; off >= 1; off--) begin
         if (i_valid[NB_ID'((int'(i_last) + off) % N_REQ)]) begin
            o_grant_idx = NB_ID'((int'(i_last) + off) % N_REQ);
            o_any       = 1'b1;
         end
      end
      o_grant_onehot = o_any ? (N_REQ'(1) << o_grant_idx) : '0;
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin sequencer sharing one uart_tx among N_REQ byte producers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter int N_REQ         = 4,
   parameter int NB_DATA       = 8,
   parameter int NB_STOP       = 1,
   parameter int TICKS_PER_BIT = uart_pkg::TICKS_PER_BIT,
   parameter int GUARD_TICKS   = 2,
   parameter int NB_ID         = $clog2(N_REQ)
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_tick,
   input  logic [N_REQ-1:0]         i_req_valid,
   input  logic [N_REQ*NB_DATA-1:0] i_req_data,
   output logic [N_REQ-1:0]         o_req_ready,
   output logic                     o_tx_start,
   output logic [NB_DATA-1:0]       o_tx_data,
   output logic                     o_busy,
   output logic [NB_ID-1:0]         o_grant_id
);

   import uart_pkg::*;

   localparam int                WAIT_TICKS = wait_ticks(TICKS_PER_BIT, NB_DATA, NB_STOP, GUARD_TICKS);
   localparam int                NB_CNT     = $clog2(WAIT_TICKS + 1);
   localparam logic [NB_CNT-1:0] C_CNT_LAST = NB_CNT'(WAIT_TICKS - 1);
   localparam logic [NB_ID-1:0]  C_LAST_RST = NB_ID'(N_REQ - 1);

   arb_state_e         state_q, state_d;
   logic               tx_start_q, tx_start_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               busy_q, busy_d;
   logic [NB_ID-1:0]   grant_id_q, grant_id_d;
   logic [NB_CNT-1:0]  cnt_q, cnt_d;

   logic [N_REQ-1:0]   sel_onehot;
   logic [NB_ID-1:0]   sel_idx;
   logic               sel_any;

   // The last accepted index doubles as the round-robin pointer.
   rr_priority_select #(
      .N_REQ (N_REQ),
      .NB_ID (NB_ID)
   ) u_rr_select (
      .i_valid        (i_req_valid),
      .i_last         (grant_id_q),
      .o_grant_onehot (sel_onehot),
      .o_grant_idx    (sel_idx),
      .o_any          (sel_any)
   );

   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      busy_d     = busy_q;
      grant_id_d = grant_id_q;
      cnt_d      = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            busy_d = 1'b0;
            if (sel_any) begin
               tx_data_d  = i_req_data[sel_idx*NB_DATA +: NB_DATA];
               grant_id_d = sel_idx;
               tx_start_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = ARB_START;
            end
         end
         ARB_START: begin
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ARB_WAIT;
         end
         ARB_WAIT: begin
            busy_d = 1'b1;
            if (i_tick) begin
               if (cnt_q == C_CNT_LAST) begin
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  state_d = ARB_IDLE;
               end else begin
                  cnt_d = cnt_q + NB_CNT'(1);
               end
            end
         end
         default: begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= ARB_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '1;
         busy_q     <= 1'b0;
         grant_id_q <= C_LAST_RST;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         grant_id_q <= grant_id_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_req_ready = (state_q == ARB_IDLE) ? sel_onehot : '0;
   assign o_tx_start  = tx_start_q;
   assign o_tx_data   = tx_data_q;
   assign o_busy      = busy_q;
   assign o_grant_id  = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Randomized bench with a frame-level reference model for uart_tx_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

   localparam int N_REQ      = 4;
   localparam int NB_DATA    = 8;
   localparam int NB_ID      = 2;
   localparam int WAIT_TICKS = 16 * (1 + 8 + 1) + 2;

   logic                     i_clock = 1'b0;
   logic                     i_reset = 1'b1;
   logic                     i_tick  = 1'b0;
   logic [N_REQ-1:0]         i_req_valid = '0;
   logic [N_REQ*NB_DATA-1:0] i_req_data  = '0;
   logic [N_REQ-1:0]         o_req_ready;
   logic                     o_tx_start;
   logic [NB_DATA-1:0]       o_tx_data;
   logic                     o_busy;
   logic [NB_ID-1:0]         o_grant_id;

   uart_tx_arbiter #(
      .N_REQ (N_REQ), .NB_DATA (NB_DATA), .NB_STOP (1),
      .TICKS_PER_BIT (16), .GUARD_TICKS (2), .NB_ID (NB_ID)
   ) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_tick      (i_tick),
      .i_req_valid (i_req_valid),
      .i_req_data  (i_req_data),
      .o_req_ready (o_req_ready),
      .o_tx_start  (o_tx_start),
      .o_tx_data   (o_tx_data),
      .o_busy      (o_busy),
      .o_grant_id  (o_grant_id)
   );

   always #5 i_clock = ~i_clock;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Baud ticks: random 1-cycle pulses, roughly one every three cycles.
   initial forever begin
      @(posedge i_clock); #1;
      i_tick = ($urandom_range(0, 2) == 0);
   end

   // ---------------- reference model ----------------
   bit               m_on = 1'b0;
   bit               m_idle, m_start;
   logic [7:0]       m_data;
   int               m_last, m_ticks, m_g;
   logic [N_REQ-1:0] m_ready;
   logic [7:0]       starts[$];
   int               gids[$];

   // Requester whose distance after 'last' (mod N_REQ) is smallest; -1 if none.
   function automatic int pick(input logic [N_REQ-1:0] v, input int last);
      int best  = -1;
      int bestd = N_REQ;
      for (int k = 0; k < N_REQ; k++) begin
         if (v[k] && ((k - last - 1 + 2*N_REQ) % N_REQ) < bestd) begin
            bestd = (k - last - 1 + 2*N_REQ) % N_REQ;
            best  = k;
         end
      end
      return best;
   endfunction

   initial forever begin
      @(negedge i_clock);
      m_g = pick(i_req_valid, m_last);
      if (m_on) begin
         m_ready = (m_idle && m_g >= 0) ? N_REQ'(1 << m_g) : '0;
         chk("ready",    32'(o_req_ready), 32'(m_ready));
         chk("start",    32'(o_tx_start),  32'(m_start));
         chk("busy",     32'(o_busy),      32'(!m_idle));
         chk("data",     32'(o_tx_data),   32'(m_data));
         chk("grant_id", 32'(o_grant_id),  32'(m_last));
         if (o_tx_start === 1'b1) begin
            starts.push_back(o_tx_data);
            gids.push_back(int'(o_grant_id));
         end
      end
      if (i_reset) begin
         m_on = 1'b1; m_idle = 1'b1; m_start = 1'b0;
         m_data = 8'hFF; m_last = N_REQ - 1; m_ticks = 0;
      end else if (m_on) begin
         if (m_idle) begin
            if (m_g >= 0) begin
               m_idle = 1'b0; m_start = 1'b1; m_ticks = 0;
               m_data = i_req_data[m_g*NB_DATA +: NB_DATA];
               m_last = m_g;
            end
         end else if (m_start) begin
            m_start = 1'b0;
         end else if (i_tick) begin
            m_ticks++;
            if (m_ticks == WAIT_TICKS) m_idle = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge i_clock); #1; end
   endtask

   task automatic set_byte(input int k, input logic [7:0] b);
      i_req_data[k*NB_DATA +: NB_DATA] = b;
   endtask

   task automatic wait_starts(input int n, input int budget, input string name);
      int c = 0;
      while (starts.size() < n && c < budget) begin step(1); c++; end
      chk(name, 32'(starts.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int c = 0;
      while (o_busy !== 1'b0 && c < budget) begin step(1); c++; end
      chk(name, 32'(o_busy), 32'd0);
   endtask

   task automatic do_reset(input int n);
      i_reset = 1'b1; step(n); i_reset = 1'b0;
   endtask

   int base, nticks, cyc;

   initial begin
      // 1: reset, no requests
      step(3); i_reset = 1'b0;
      step(50);
      @(negedge i_clock);
      chk("p1_ready", 32'(o_req_ready), 32'd0);
      chk("p1_busy",  32'(o_busy),      32'd0);
      chk("p1_start", 32'(o_tx_start),  32'd0);
      chk("p1_data",  32'(o_tx_data),   32'hFF);
      chk("p1_gid",   32'(o_grant_id),  32'd3);

      // 2: single byte A5 from requester 0, busy for exactly WAIT_TICKS ticks
      step(1);
      set_byte(0, 8'hA5); i_req_valid = 4'b0001;
      cyc = 0;
      do begin @(negedge i_clock); cyc++; end while (o_req_ready !== 4'b0001 && cyc < 10);
      chk("p2_ready", 32'(o_req_ready), 32'd1);
      @(posedge i_clock); #1; i_req_valid = '0;
      @(negedge i_clock);
      chk("p2_start", 32'(o_tx_start), 32'd1);
      chk("p2_data",  32'(o_tx_data),  32'hA5);
      chk("p2_gid",   32'(o_grant_id), 32'd0);
      nticks = 0; cyc = 0;
      forever begin
         @(negedge i_clock); cyc++;
         if (o_busy !== 1'b1 || cyc > 4000) break;
         if (i_tick) nticks++;
      end
      chk("p2_busy_ticks", nticks, 162);

      // 3: all four requesting, strict rotation from requester 0
      step(2); do_reset(2);
      for (int k = 0; k < N_REQ; k++) set_byte(k, 8'(8'h10 + k));
      base = starts.size();
      i_req_valid = 4'b1111;
      wait_starts(base + 5, 8000, "p3_timeout");
      i_req_valid = '0;
      chk("p3_seq0", 32'(starts[base]),   32'h10);
      chk("p3_seq1", 32'(starts[base+1]), 32'h11);
      chk("p3_seq2", 32'(starts[base+2]), 32'h12);
      chk("p3_seq3", 32'(starts[base+3]), 32'h13);
      chk("p3_seq4", 32'(starts[base+4]), 32'h10);
      wait_idle(3000, "p3_idle");

      // 4: last = 1, then 1001 -> requester 3 before 0
      base = starts.size();
      i_req_valid = 4'b0010;
      wait_starts(base + 1, 100, "p4_first");
      i_req_valid = 4'b1001;
      wait_starts(base + 3, 6000, "p4_timeout");
      i_req_valid = '0;
      chk("p4_r1",  32'(starts[base]),   32'h11);
      chk("p4_r3",  32'(starts[base+1]), 32'h13);
      chk("p4_r0",  32'(starts[base+2]), 32'h10);
      chk("p4_g3",  32'(gids[base+1]),   32'd3);
      chk("p4_g0",  32'(gids[base+2]),   32'd0);
      wait_idle(3000, "p4_idle");

      // 5: valid pulsed only during WAIT -> no extra frame
      base = starts.size();
      i_req_valid = 4'b0100;
      wait_starts(base + 1, 100, "p5_first");
      i_req_valid = '0;
      step(20);
      i_req_valid = 4'b1000; step(5); i_req_valid = '0;
      wait_idle(3000, "p5_idle");
      step(300);
      chk("p5_no_extra", starts.size(), base + 1);

      // 6: reset mid-frame, then a clean frame from requester 0
      base = starts.size();
      set_byte(0, 8'h3C); i_req_valid = 4'b0001;
      wait_starts(base + 1, 100, "p6_first");
      i_req_valid = '0;
      step(100);
      do_reset(1);
      @(negedge i_clock);
      chk("p6_busy",  32'(o_busy),      32'd0);
      chk("p6_start", 32'(o_tx_start),  32'd0);
      chk("p6_data",  32'(o_tx_data),   32'hFF);
      chk("p6_gid",   32'(o_grant_id),  32'd3);
      step(1);
      set_byte(0, 8'h55); i_req_valid = 4'b0001;
      wait_starts(base + 2, 100, "p6_second");
      i_req_valid = '0;
      chk("p6_data2", 32'(starts[base+1]), 32'h55);
      chk("p6_gid2",  32'(gids[base+1]),   32'd0);

      // 7: randomized traffic with occasional resets
      for (int c = 0; c < 15000; c++) begin
         if ($urandom_range(0, 7) == 0)  i_req_valid = N_REQ'($urandom);
         if ($urandom_range(0, 15) == 0) i_req_data  = $urandom;
         i_reset = ($urandom_range(0, 4999) == 0);
         step(1);
      end
      i_reset = 1'b0;
      i_req_valid = '0;
      step(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
